// File: rtl/onehot_sender_if.sv
// Event-strobe / one-hot pulse bus between an event source and onehot_sender.
// The master drives the strobe and the slave drives the pulse bus.
interface onehot_sender_if #(
    parameter int WIDTH = 8
) ();
    logic             in;
    logic [WIDTH-1:0] out;

    modport master (
        output in,
        input  out
    );

    modport slave (
        input  in,
        output out
    );
endinterface

// File: rtl/onehot_sender.sv
// Counts input events and replays each one as a single-cycle one-hot pulse,
// rotating across WIDTH channels with at least GAP idle cycles between pulses.
module onehot_sender #(
    parameter int WIDTH       = 8,
    parameter int GAP         = 1,
    parameter int MAX_PENDING = 15
) (
    input  logic            clk,
    input  logic            rst,
    onehot_sender_if.slave  bus
);
    localparam int PW    = $clog2(MAX_PENDING + 1);
    localparam int PTR_W = $clog2(WIDTH);
    localparam int CW    = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        READY = 2'd0,
        SEND  = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t             state_r;
    logic [PW-1:0]      pending_r;
    logic [PTR_W-1:0]   ptr_r;
    logic [CW-1:0]      cool_r;
    logic [WIDTH-1:0]   out_r;

    logic               fire_s;
    logic               accept_s;
    logic [PW-1:0]      pending_nxt_s;

    function automatic logic [WIDTH-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH; i++) begin
            v[i] = (idx == PTR_W'(i));
        end
        return v;
    endfunction

    assign fire_s   = (state_r == READY) && (pending_r != {PW{1'b0}});
    // A full counter still takes an event when a pulse frees a slot that cycle.
    assign accept_s = bus.in && ((pending_r != PW'(MAX_PENDING)) || fire_s);
    assign bus.out  = out_r;

    // Next pending count: +1 per accepted event, -1 per pulse issued.
    always_comb begin
        pending_nxt_s = pending_r;
        if (accept_s && !fire_s) begin
            pending_nxt_s = pending_r + PW'(1'b1);
        end else if (fire_s && !accept_s) begin
            pending_nxt_s = pending_r - PW'(1'b1);
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Pulse FSM with registered one-hot output, channel pointer and cooldown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= READY;
            pending_r <= {PW{1'b0}};
            ptr_r     <= {PTR_W{1'b0}};
            cool_r    <= {CW{1'b0}};
            out_r     <= {WIDTH{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
            case (state_r)
                READY: begin
                    if (fire_s) begin
                        out_r   <= onehot(ptr_r);
                        state_r <= SEND;
                        if (ptr_r == PTR_W'(WIDTH - 1)) begin
                            ptr_r <= {PTR_W{1'b0}};
                        end else begin
                            ptr_r <= ptr_r + PTR_W'(1'b1);
                        end
                    end else begin
                        out_r   <= {WIDTH{1'b0}};
                        state_r <= READY;
                    end
                end
                SEND: begin
                    out_r <= {WIDTH{1'b0}};
                    if (GAP == 0) begin
                        state_r <= READY;
                        cool_r  <= {CW{1'b0}};
                    end else begin
                        state_r <= COOL;
                        cool_r  <= CW'(GAP);
                    end
                end
                COOL: begin
                    out_r <= {WIDTH{1'b0}};
                    // Leave on the edge where the counter lands on zero.
                    if (cool_r <= CW'(1'b1)) begin
                        cool_r  <= {CW{1'b0}};
                        state_r <= READY;
                    end else begin
                        cool_r  <= cool_r - CW'(1'b1);
                        state_r <= COOL;
                    end
                end
                default: begin
                    out_r   <= {WIDTH{1'b0}};
                    cool_r  <= {CW{1'b0}};
                    state_r <= READY;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_onehot_sender.sv
// Scoreboard bench for onehot_sender: a GAP=1 and a GAP=0 instance share one
// event strobe; a cycle model queues expected pulses and checks every cycle.
module tb_onehot_sender;
    localparam int W    = 8;
    localparam int MAXP = 15;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic in_drv = 1'b0;
    logic rst_q  = 1'b1;
    logic in_q   = 1'b0;

    int tests = 0;
    int fails = 0;

    int m_pend  [2];
    int m_wait  [2];
    int m_ptr   [2];
    int m_zeros [2];
    int m_seen  [2];
    logic [W-1:0] sb0 [$];
    logic [W-1:0] sb1 [$];

    always #5 clk = ~clk;

    onehot_sender_if #(.WIDTH(W)) bus0 ();
    onehot_sender_if #(.WIDTH(W)) bus1 ();
    assign bus0.in = in_drv;
    assign bus1.in = in_drv;

    onehot_sender #(.WIDTH(W), .GAP(1), .MAX_PENDING(MAXP)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    onehot_sender #(.WIDTH(W), .GAP(0), .MAX_PENDING(MAXP)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Capture what the DUTs sampled at each rising edge.
    always @(posedge clk) begin
        rst_q <= rst;
        in_q  <= in_drv;
    end

    task automatic step_model(input int d, input logic [W-1:0] obs);
        int gap;
        logic fire;
        logic acc;
        logic [W-1:0] exp_v;
        gap = (d == 0) ? 1 : 0;
        tests++;
        if (obs != '0 && !$onehot(obs)) begin
            fails++;
            $display("FAIL onehot_dut%0d: out=%h, required zero or one-hot", d, obs);
        end
        if (rst_q) begin
            m_pend[d] = 0; m_wait[d] = 0; m_ptr[d] = 0; m_seen[d] = 0; m_zeros[d] = 0;
            if (d == 0) sb0.delete(); else sb1.delete();
            tests++;
            if (obs !== '0) begin
                fails++;
                $display("FAIL reset_out_dut%0d: out=%h, required 00", d, obs);
            end
        end else begin
            fire = (m_wait[d] == 0) && (m_pend[d] > 0);
            acc  = in_q && ((m_pend[d] < MAXP) || fire);
            if (acc) begin
                exp_v = 8'h01 << m_ptr[d];
                if (d == 0) sb0.push_back(exp_v); else sb1.push_back(exp_v);
                m_ptr[d] = (m_ptr[d] + 1) % W;
            end
            m_pend[d] = m_pend[d] + (acc ? 1 : 0) - (fire ? 1 : 0);
            if (fire) m_wait[d] = gap + 1;
            else if (m_wait[d] > 0) m_wait[d] = m_wait[d] - 1;
            if (fire) begin
                exp_v = '0;
                if (d == 0 && sb0.size() > 0) exp_v = sb0.pop_front();
                else if (d == 1 && sb1.size() > 0) exp_v = sb1.pop_front();
                tests++;
                if (obs !== exp_v) begin
                    fails++;
                    $display("FAIL pulse_dut%0d: out=%h, required %h", d, obs, exp_v);
                end
            end else begin
                tests++;
                if (obs !== '0) begin
                    fails++;
                    $display("FAIL idle_dut%0d: out=%h, required 00", d, obs);
                end
            end
            if (obs != '0) begin
                if (m_seen[d] != 0) begin
                    tests++;
                    if (m_zeros[d] < gap + 1) begin
                        fails++;
                        $display("FAIL spacing_dut%0d: %0d zero cycles, required >= %0d", d, m_zeros[d], gap + 1);
                    end
                end
                m_seen[d]  = 1;
                m_zeros[d] = 0;
            end else begin
                m_zeros[d] = m_zeros[d] + 1;
            end
        end
    endtask

    task automatic tick;
        @(negedge clk);
        step_model(0, bus0.out);
        step_model(1, bus1.out);
    endtask

    task automatic do_reset;
        rst = 1'b1; in_drv = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_drv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (bus0.out !== 8'h00 || bus1.out !== 8'h00) begin
                fails++;
                $display("FAIL reset_hold: out0=%h out1=%h, required 00", bus0.out, bus1.out);
            end
        end
        rst = 1'b0;
        tick();
        in_drv = 1'b0;
        tests++;
        if (bus0.out !== 8'h00) begin
            fails++;
            $display("FAIL latency_k: out=%h, required 00", bus0.out);
        end
        tick();
        tests++;
        if (bus0.out !== 8'h01 || bus1.out !== 8'h01) begin
            fails++;
            $display("FAIL latency_k1: out0=%h out1=%h, required 01", bus0.out, bus1.out);
        end
        tick();
        tests++;
        if (bus0.out !== 8'h00 || bus1.out !== 8'h00) begin
            fails++;
            $display("FAIL latency_k2: out0=%h out1=%h, required 00", bus0.out, bus1.out);
        end
        repeat (4) tick();
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] v0 [$];
        logic [W-1:0] v1 [$];
        int c0 [$];
        int c1 [$];
        logic [W-1:0] e;
        do_reset();
        in_drv = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c == 2) in_drv = 1'b0;
            if (bus0.out != '0) begin v0.push_back(bus0.out); c0.push_back(c); end
            if (bus1.out != '0) begin v1.push_back(bus1.out); c1.push_back(c); end
        end
        tests++;
        if (v0.size() != 3 || v1.size() != 3) begin
            fails++;
            $display("FAIL b2b_count: got %0d/%0d pulses, required 3/3", v0.size(), v1.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                e = 8'h01 << i;
                tests++;
                if (v0[i] !== e || c0[i] != 1 + 3 * i) begin
                    fails++;
                    $display("FAIL b2b_gap1_%0d: out=%h at cycle %0d, required %h at %0d", i, v0[i], c0[i], e, 1 + 3 * i);
                end
                tests++;
                if (v1[i] !== e || c1[i] != 1 + 2 * i) begin
                    fails++;
                    $display("FAIL b2b_gap0_%0d: out=%h at cycle %0d, required %h at %0d", i, v1[i], c1[i], e, 1 + 2 * i);
                end
            end
        end
    endtask

    task automatic test_rotation;
        logic [W-1:0] v0 [$];
        logic [W-1:0] e;
        do_reset();
        for (int n = 0; n < 9; n++) begin
            in_drv = 1'b1;
            for (int c = 0; c < 5; c++) begin
                tick();
                in_drv = 1'b0;
                if (bus0.out != '0) v0.push_back(bus0.out);
            end
        end
        tests++;
        if (v0.size() != 9) begin
            fails++;
            $display("FAIL rotation_count: got %0d pulses, required 9", v0.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                e = 8'h01 << (i % W);
                tests++;
                if (v0[i] !== e) begin
                    fails++;
                    $display("FAIL rotation_%0d: out=%h, required %h", i, v0[i], e);
                end
            end
        end
    endtask

    task automatic test_saturation;
        int b0, b1, t0, t1;
        b0 = 0; b1 = 0;
        do_reset();
        in_drv = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 39) in_drv = 1'b0;
            if (bus0.out != '0) b0++;
            if (bus1.out != '0) b1++;
        end
        t0 = b0; t1 = b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus0.out != '0) t0++;
            if (bus1.out != '0) t1++;
        end
        tests++;
        if (b0 != 13 || b1 != 20) begin
            fails++;
            $display("FAIL sat_burst_fires: got %0d/%0d, required 13/20", b0, b1);
        end
        tests++;
        if (t0 != b0 + MAXP || t1 != b1 + MAXP) begin
            fails++;
            $display("FAIL sat_total: got %0d/%0d, required %0d/%0d", t0, t1, b0 + MAXP, b1 + MAXP);
        end
        tests++;
        if (t0 != 28 || t1 != 35) begin
            fails++;
            $display("FAIL sat_total_abs: got %0d/%0d, required 28/35", t0, t1);
        end
    endtask

    task automatic test_reset_mid;
        int seen, cnt;
        logic hit;
        seen = 0; cnt = 0; hit = 1'b0;
        do_reset();
        in_drv = 1'b1;
        for (int c = 0; c < 40 && !hit; c++) begin
            tick();
            if (c == 4) in_drv = 1'b0;
            if (bus0.out != '0) begin
                seen++;
                if (seen == 2) hit = 1'b1;
            end
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL rst_mid_timeout: saw %0d pulses, required 2", seen);
        end
        rst = 1'b1; in_drv = 1'b0;
        tick();
        rst = 1'b0;
        tests++;
        if (bus0.out !== 8'h00 || bus1.out !== 8'h00) begin
            fails++;
            $display("FAIL rst_mid_out: out0=%h out1=%h, required 00", bus0.out, bus1.out);
        end
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus0.out != '0 || bus1.out != '0) cnt++;
        end
        tests++;
        if (cnt != 0) begin
            fails++;
            $display("FAIL rst_mid_flush: %0d stray pulse cycles, required 0", cnt);
        end
        in_drv = 1'b1;
        tick();
        in_drv = 1'b0;
        tick();
        tests++;
        if (bus0.out !== 8'h01) begin
            fails++;
            $display("FAIL rst_mid_first: out=%h, required 01", bus0.out);
        end
        repeat (4) tick();
    endtask

    task automatic test_random;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c < 200) in_drv = ($urandom_range(0, 3) == 0);
            else         in_drv = ($urandom_range(0, 1) == 1);
            tick();
        end
        in_drv = 1'b0;
        repeat (100) tick();
        tests++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            fails++;
            $display("FAIL random_drain: %0d/%0d accepted events without pulse, required 0/0", sb0.size(), sb1.size());
        end
        tests++;
        if (m_pend[0] != 0 || m_pend[1] != 0) begin
            fails++;
            $display("FAIL random_pending: model pending %0d/%0d, required 0/0", m_pend[0], m_pend[1]);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_rotation();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
